timer_irq_arbiter: RTL and testbench
====================================

TIMER_IRQ_ARBITER -- requirements
Module: timer_irq_arbiter

Interface
REQ-001 SHALL have parameter NUM_TIMERS, default 4, number of timer interrupt sources (2..16).
REQ-002 SHALL have parameter ID_W, default 2, width of grant ID, equal to clog2(NUM_TIMERS).
REQ-003 SHALL have port ACLK, input, 1: sole clock, all state updates on rising edge.
REQ-004 SHALL have port ARESET, input, 1: reset; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port TimerIrq, input, NUM_TIMERS: one-cycle interrupt pulses from timer instances.
REQ-006 SHALL have port IrqReq, output, 1: interrupt request to core.
REQ-007 SHALL have port IrqId, output, ID_W: index of the granted timer, valid while IrqReq=1.
REQ-008 SHALL have port IrqAck, input, 1: core acknowledge of the current request.
REQ-009 SHALL have port Pending, output, NUM_TIMERS: registered pending bits.
REQ-010 SHALL have port Overrun, output, NUM_TIMERS: sticky lost-pulse flags.
REQ-011 SHALL have ports WriteAddr (input, 64), WriteData (input, 64), WriteStrb (input, 4) and SlaverWriteReady (output, 1): bus write slave.

Function
REQ-012 SHALL set Pending[i] on the clock edge after TimerIrq[i]=1.
REQ-013 SHALL set Overrun[i] when TimerIrq[i]=1 while Pending[i] is already 1.
REQ-014 SHALL implement FSM states IDLE, REQ, GAP.
REQ-015 In IDLE with any eligible bit (Pending & Mask) nonzero, SHALL register IrqId with the round-robin winner, move to REQ, and drive IrqReq=1 from the next cycle.
REQ-016 Round-robin SHALL search upward from pointer Ptr, wrapping from NUM_TIMERS-1 to 0.
REQ-017 In REQ, IrqReq and IrqId SHALL hold stable until IrqAck=1; IrqAck outside REQ SHALL be ignored.
REQ-018 On IrqAck in REQ, SHALL clear Pending[IrqId] and Overrun[IrqId], set Ptr=IrqId+1 (wrap to 0), and go to GAP.
REQ-019 If TimerIrq[IrqId]=1 in the same cycle as the acknowledge, Pending[IrqId] SHALL remain 1 and Overrun[IrqId] SHALL be cleared.
REQ-020 GAP SHALL last exactly one cycle with IrqReq=0, then go to IDLE.
REQ-021 Latency from a TimerIrq pulse in cycle 0 on an idle arbiter SHALL be IrqReq=1 in cycle 2.
REQ-022 Simultaneous pulses SHALL each be latched; none SHALL be lost.

Reset
REQ-023 On ARESET=1 at an edge: state=IDLE, Ptr=0, Pending=0, Overrun=0, IrqReq=0, IrqId=0, SlaverWriteReady=0, Mask=all ones.
REQ-024 Reset asserted in REQ SHALL drop IrqReq on the next edge with no acknowledge required.

Configuration
REQ-025 Macro TIMER_IRQ_MASK_EN SHALL control the mask register.
REQ-026 With TIMER_IRQ_MASK_EN defined: a write to 64'h5000_0100 with WriteStrb[0]=1 SHALL load Mask from WriteData[NUM_TIMERS-1:0] and pulse SlaverWriteReady=1 for one cycle.
REQ-027 With TIMER_IRQ_MASK_EN defined: masked sources SHALL still latch Pending and Overrun but SHALL not be granted.
REQ-028 Without TIMER_IRQ_MASK_EN: Mask SHALL be constant all ones, write ports SHALL be ignored, and SlaverWriteReady SHALL be 0.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, the mask address constant, and the NUM_TIMERS/ID_W defaults.
REQ-030 SHALL use one sub-module, rr_pick (round-robin find-first from pointer), which is combinational and parameterised by width.

Verification
REQ-031 Scenario: TimerIrq=4'b0100 in cycle 0 -> IrqReq=1 and IrqId=2 in cycle 2; IrqAck in cycle 4 -> Pending=0 in cycle 5, IrqReq=0 in cycles 5-6.
REQ-032 Scenario: TimerIrq=4'b1011 at once, ack each grant -> IrqId sequence 0,1,3, then Ptr=0.
REQ-033 Scenario: pulse timer 1 twice before ack -> Overrun[1]=1; after ack -> Overrun[1]=0 and Pending[1]=0.
REQ-034 Scenario: pulse timer 3 in the same cycle as ack of IrqId=3 -> Pending[3] stays 1, re-granted after GAP.
REQ-035 Scenario (TIMER_IRQ_MASK_EN): write Mask=4'b1110, pulse timer 0 -> no IrqReq while Pending[0]=1; write Mask=4'b1111 -> IrqId=0 granted.
REQ-036 Scenario: ARESET in REQ -> next cycle IrqReq=0, Pending=0, state=IDLE.

Source files
------------

// File: rtl/timer_irq_arbiter_pkg.sv
// Shared constants for the timer interrupt arbiter: FSM encoding, mask
// register address and default sizing.
package timer_irq_arbiter_pkg;

  localparam int DEFAULT_NUM_TIMERS = 4;
  localparam int DEFAULT_ID_W       = 2;

  localparam logic [63:0] MASK_ADDR = 64'h5000_0100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/timer_irq_arbiter_rr_pick.sv
// Combinational round-robin find-first: returns the first set request bit
// at or above i_ptr, wrapping from WIDTH-1 back to 0.
module rr_pick
  import timer_irq_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_NUM_TIMERS,
  parameter int ID_W  = DEFAULT_ID_W
) (
  input  logic [WIDTH-1:0] i_req,
  input  logic [ID_W-1:0]  i_ptr,
  output logic             o_valid,
  output logic [ID_W-1:0]  o_id
);

  always_comb begin
    int idx;
    // NOTE: every output gets a default before the loop so no latch is inferred.
    o_valid = 1'b0;
    o_id    = '0;
    idx     = 0;
    for (int k = 0; k < WIDTH; k++) begin
      idx = (int'(i_ptr) + k) % WIDTH;
      if (!o_valid && i_req[idx]) begin
        o_valid = 1'b1;
        o_id    = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/timer_irq_arbiter.sv
// Round-robin arbiter turning one-cycle timer pulses into a single acked
// interrupt request. Define TIMER_IRQ_MASK_EN to add the bus-writable mask.
module timer_irq_arbiter
  import timer_irq_arbiter_pkg::*;
#(
  parameter int NUM_TIMERS = DEFAULT_NUM_TIMERS,
  parameter int ID_W       = DEFAULT_ID_W
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [NUM_TIMERS-1:0] TimerIrq,
  output logic                  IrqReq,
  output logic [ID_W-1:0]       IrqId,
  input  logic                  IrqAck,
  output logic [NUM_TIMERS-1:0] Pending,
  output logic [NUM_TIMERS-1:0] Overrun,
  input  logic [63:0]           WriteAddr,
  input  logic [63:0]           WriteData,
  input  logic [3:0]            WriteStrb,
  output logic                  SlaverWriteReady
);

  logic [1:0]            r_state;
  logic [ID_W-1:0]       r_ptr;
  logic [ID_W-1:0]       r_irq_id;
  logic                  r_irq_req;
  logic [NUM_TIMERS-1:0] r_pending;
  logic [NUM_TIMERS-1:0] r_overrun;

  logic [NUM_TIMERS-1:0] w_mask;
  logic [NUM_TIMERS-1:0] w_ack_clr;
  logic [NUM_TIMERS-1:0] w_pending_nxt;
  logic [NUM_TIMERS-1:0] w_overrun_nxt;
  logic [ID_W-1:0]       w_ptr_nxt;
  logic [ID_W-1:0]       w_win_id;
  logic                  w_win_valid;
  logic                  w_ack;
  logic                  w_unused_wr;

  assign w_ack     = (r_state == ST_REQ) && IrqAck;
  assign w_ack_clr = w_ack ? (NUM_TIMERS'(1) << r_irq_id) : '0;

  // A pulse arriving with the ack re-arms Pending, but the ack still wins on Overrun.
  assign w_pending_nxt = (r_pending & ~w_ack_clr) | TimerIrq;
  assign w_overrun_nxt = (r_overrun | (TimerIrq & r_pending)) & ~w_ack_clr;
  assign w_ptr_nxt     = (r_irq_id == ID_W'(NUM_TIMERS - 1)) ? '0 : r_irq_id + 1'b1;

  rr_pick #(
    .WIDTH (NUM_TIMERS),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .i_req   (r_pending & w_mask),
    .i_ptr   (r_ptr),
    .o_valid (w_win_valid),
    .o_id    (w_win_id)
  );

  always_ff @(posedge ACLK) begin
    // NOTE: reset is sampled on the clock edge; state uses non-blocking assignments only.
    if (ARESET) begin
      r_state   <= ST_IDLE;
      r_ptr     <= '0;
      r_irq_id  <= '0;
      r_irq_req <= 1'b0;
      r_pending <= '0;
      r_overrun <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      case (r_state)
        ST_IDLE: begin
          if (w_win_valid) begin
            r_irq_id  <= w_win_id;
            r_irq_req <= 1'b1;
            r_state   <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (IrqAck) begin
            r_irq_req <= 1'b0;
            r_ptr     <= w_ptr_nxt;
            r_state   <= ST_GAP;
          end
        end
        ST_GAP:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef TIMER_IRQ_MASK_EN
  logic [NUM_TIMERS-1:0] r_mask;
  logic                  r_wr_ready;
  logic                  w_mask_wr;

  assign w_mask_wr = (WriteAddr == MASK_ADDR) && WriteStrb[0];

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_mask     <= '1;
      r_wr_ready <= 1'b0;
    end else begin
      r_wr_ready <= w_mask_wr;
      if (w_mask_wr) r_mask <= WriteData[NUM_TIMERS-1:0];
    end
  end

  assign w_mask           = r_mask;
  assign SlaverWriteReady = r_wr_ready;
  assign w_unused_wr      = ^{WriteData[63:NUM_TIMERS], WriteStrb[3:1]};
`else
  assign w_mask           = '1;
  assign SlaverWriteReady = 1'b0;
  assign w_unused_wr      = ^{WriteAddr, WriteData, WriteStrb};
`endif

  assign IrqReq  = r_irq_req;
  assign IrqId   = r_irq_id;
  assign Pending = r_pending;
  assign Overrun = r_overrun;

endmodule

// File: tb/tb_timer_irq_arbiter.sv
// Self-checking bench for timer_irq_arbiter: directed scenarios plus a
// randomized run against a behavioural model of the arbitration rules.
module tb_timer_irq_arbiter;

  localparam logic [63:0] MASK_ADDR = 64'h5000_0100;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  TimerIrq = '0;
  logic        IrqAck = 1'b0;
  logic        IrqReq;
  logic [1:0]  IrqId;
  logic [3:0]  Pending;
  logic [3:0]  Overrun;
  logic [63:0] WriteAddr = '0;
  logic [63:0] WriteData = '0;
  logic [3:0]  WriteStrb = '0;
  logic        SlaverWriteReady;

  int n_checks = 0;
  int n_fails  = 0;

  // Behavioural model state
  logic [3:0] m_pend, m_ovr, m_mask;
  logic       m_req, m_gap, m_ready;
  int         m_id, m_ptr;

  timer_irq_arbiter #(.NUM_TIMERS(4), .ID_W(2)) dut (
    .ACLK             (ACLK),
    .ARESET           (ARESET),
    .TimerIrq         (TimerIrq),
    .IrqReq           (IrqReq),
    .IrqId            (IrqId),
    .IrqAck           (IrqAck),
    .Pending          (Pending),
    .Overrun          (Overrun),
    .WriteAddr        (WriteAddr),
    .WriteData        (WriteData),
    .WriteStrb        (WriteStrb),
    .SlaverWriteReady (SlaverWriteReady)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "watchdog expired");
  end

  // Advances the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic [3:0] old_pend;
    int         found;
    int         j;
    logic       wr_hit;
    if (ARESET) begin
      m_pend = '0; m_ovr = '0; m_mask = '1;
      m_req = 0; m_gap = 0; m_ready = 0; m_id = 0; m_ptr = 0;
      return;
    end
    old_pend = m_pend;
    for (int i = 0; i < 4; i++) begin
      if (TimerIrq[i]) begin
        if (m_pend[i]) m_ovr[i] = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    if (m_req) begin
      if (IrqAck) begin
        m_pend[m_id] = TimerIrq[m_id];
        m_ovr[m_id]  = 1'b0;
        m_ptr        = (m_id + 1) % 4;
        m_req        = 0;
        m_gap        = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else begin
      found = -1;
      for (int k = 0; k < 4; k++) begin
        j = (m_ptr + k) % 4;
        if (found < 0 && old_pend[j] && m_mask[j]) found = j;
      end
      if (found >= 0) begin
        m_req = 1;
        m_id  = found;
      end
    end
    wr_hit = 1'b0;
`ifdef TIMER_IRQ_MASK_EN
    wr_hit = (WriteAddr == MASK_ADDR) && WriteStrb[0];
    if (wr_hit) m_mask = WriteData[3:0];
`endif
    m_ready = wr_hit;
  endtask

  task automatic drive_cycle(input logic [3:0] t, input logic a);
    TimerIrq = t;
    IrqAck   = a;
    model_step();
    @(posedge ACLK);
    #1;
    TimerIrq = '0;
    IrqAck   = 1'b0;
  endtask

  task automatic do_reset();
    ARESET = 1'b1;
    drive_cycle(4'b0000, 1'b0);
    ARESET = 1'b0;
  endtask

  task automatic bus_write(input logic [63:0] addr, input logic [63:0] data, input logic [3:0] strb);
    WriteAddr = addr; WriteData = data; WriteStrb = strb;
    drive_cycle(4'b0000, 1'b0);
    WriteAddr = '0; WriteData = '0; WriteStrb = '0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (IrqReq !== 1'b1 && n < 20) begin
      drive_cycle(4'b0000, 1'b0);
      n++;
    end
    n_checks++;
    if (IrqReq !== 1'b1) begin
      n_fails++;
      $display("FAIL %s: IrqReq=%b after %0d cycles, required 1", name, IrqReq, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (IrqReq !== 1'b0) begin n_fails++; $display("FAIL rst_req: IrqReq=%b expected 0", IrqReq); end
    n_checks++; if (IrqId !== 2'd0) begin n_fails++; $display("FAIL rst_id: IrqId=%0d expected 0", IrqId); end
    n_checks++; if (Pending !== 4'b0000) begin n_fails++; $display("FAIL rst_pend: Pending=%b expected 0000", Pending); end
    n_checks++; if (Overrun !== 4'b0000) begin n_fails++; $display("FAIL rst_ovr: Overrun=%b expected 0000", Overrun); end
    n_checks++; if (SlaverWriteReady !== 1'b0) begin n_fails++; $display("FAIL rst_wrdy: SlaverWriteReady=%b expected 0", SlaverWriteReady); end
  endtask

  task automatic test_latency();
    do_reset();
    drive_cycle(4'b0100, 1'b0);
    n_checks++; if (IrqReq !== 1'b0) begin n_fails++; $display("FAIL lat_c1_req: IrqReq=%b expected 0", IrqReq); end
    n_checks++; if (Pending !== 4'b0100) begin n_fails++; $display("FAIL lat_c1_pend: Pending=%b expected 0100", Pending); end
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b1 || IrqId !== 2'd2) begin n_fails++; $display("FAIL lat_c2_grant: IrqReq=%b IrqId=%0d expected 1/2", IrqReq, IrqId); end
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b1 || IrqId !== 2'd2) begin n_fails++; $display("FAIL lat_c4_hold: IrqReq=%b IrqId=%0d expected 1/2", IrqReq, IrqId); end
    drive_cycle(4'b0000, 1'b1);
    n_checks++; if (Pending !== 4'b0000 || IrqReq !== 1'b0) begin n_fails++; $display("FAIL lat_c5: Pending=%b IrqReq=%b expected 0000/0", Pending, IrqReq); end
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b0) begin n_fails++; $display("FAIL lat_c6_req: IrqReq=%b expected 0", IrqReq); end
  endtask

  task automatic test_simultaneous();
    int exp_ids[3] = '{0, 1, 3};
    do_reset();
    drive_cycle(4'b1011, 1'b0);
    n_checks++; if (Pending !== 4'b1011) begin n_fails++; $display("FAIL sim_pend: Pending=%b expected 1011", Pending); end
    for (int k = 0; k < 3; k++) begin
      wait_req("sim_wait");
      n_checks++; if (IrqId !== 2'(exp_ids[k])) begin n_fails++; $display("FAIL sim_id%0d: IrqId=%0d expected %0d", k, IrqId, exp_ids[k]); end
      drive_cycle(4'b0000, 1'b1);
    end
    n_checks++; if (Pending !== 4'b0000) begin n_fails++; $display("FAIL sim_drain: Pending=%b expected 0000", Pending); end
    // Pointer wrapped to 0 after granting 3, so timer 0 beats timer 3.
    drive_cycle(4'b1001, 1'b0);
    wait_req("wrap_wait0");
    n_checks++; if (IrqId !== 2'd0) begin n_fails++; $display("FAIL wrap_first: IrqId=%0d expected 0", IrqId); end
    drive_cycle(4'b0000, 1'b1);
    wait_req("wrap_wait3");
    n_checks++; if (IrqId !== 2'd3) begin n_fails++; $display("FAIL wrap_second: IrqId=%0d expected 3", IrqId); end
    drive_cycle(4'b0000, 1'b1);
  endtask

  task automatic test_overrun();
    do_reset();
    drive_cycle(4'b0010, 1'b0);
    drive_cycle(4'b0010, 1'b0);
    n_checks++; if (Overrun !== 4'b0010 || Pending !== 4'b0010) begin n_fails++; $display("FAIL ovr_set: Overrun=%b Pending=%b expected 0010/0010", Overrun, Pending); end
    wait_req("ovr_wait");
    n_checks++; if (IrqId !== 2'd1) begin n_fails++; $display("FAIL ovr_id: IrqId=%0d expected 1", IrqId); end
    drive_cycle(4'b0000, 1'b1);
    n_checks++; if (Overrun !== 4'b0000 || Pending !== 4'b0000) begin n_fails++; $display("FAIL ovr_clr: Overrun=%b Pending=%b expected 0000/0000", Overrun, Pending); end
  endtask

  task automatic test_ack_collision();
    do_reset();
    drive_cycle(4'b1000, 1'b0);
    wait_req("col_wait");
    n_checks++; if (IrqId !== 2'd3) begin n_fails++; $display("FAIL col_id: IrqId=%0d expected 3", IrqId); end
    drive_cycle(4'b1000, 1'b1);
    n_checks++; if (Pending !== 4'b1000 || Overrun !== 4'b0000 || IrqReq !== 1'b0) begin n_fails++; $display("FAIL col_ack: Pending=%b Overrun=%b IrqReq=%b expected 1000/0000/0", Pending, Overrun, IrqReq); end
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b0) begin n_fails++; $display("FAIL col_idle: IrqReq=%b expected 0", IrqReq); end
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b1 || IrqId !== 2'd3) begin n_fails++; $display("FAIL col_regrant: IrqReq=%b IrqId=%0d expected 1/3", IrqReq, IrqId); end
    drive_cycle(4'b0000, 1'b1);
    n_checks++; if (Pending !== 4'b0000) begin n_fails++; $display("FAIL col_drain: Pending=%b expected 0000", Pending); end
  endtask

`ifdef TIMER_IRQ_MASK_EN
  task automatic test_mask();
    do_reset();
    bus_write(MASK_ADDR, 64'hE, 4'b0001);
    n_checks++; if (SlaverWriteReady !== 1'b1) begin n_fails++; $display("FAIL mask_rdy: SlaverWriteReady=%b expected 1", SlaverWriteReady); end
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (SlaverWriteReady !== 1'b0) begin n_fails++; $display("FAIL mask_rdy_pulse: SlaverWriteReady=%b expected 0", SlaverWriteReady); end
    drive_cycle(4'b0001, 1'b0);
    for (int k = 0; k < 5; k++) begin
      drive_cycle(4'b0000, 1'b0);
      n_checks++; if (IrqReq !== 1'b0 || Pending[0] !== 1'b1) begin n_fails++; $display("FAIL mask_block%0d: IrqReq=%b Pending=%b expected 0/xxx1", k, IrqReq, Pending); end
    end
    bus_write(MASK_ADDR, 64'hF, 4'b0001);
    wait_req("mask_wait");
    n_checks++; if (IrqId !== 2'd0) begin n_fails++; $display("FAIL mask_grant: IrqId=%0d expected 0", IrqId); end
    drive_cycle(4'b0000, 1'b1);
  endtask
`else
  task automatic test_no_mask();
    do_reset();
    bus_write(MASK_ADDR, 64'hE, 4'b1111);
    n_checks++; if (SlaverWriteReady !== 1'b0) begin n_fails++; $display("FAIL nomask_rdy: SlaverWriteReady=%b expected 0", SlaverWriteReady); end
    drive_cycle(4'b0001, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b1 || IrqId !== 2'd0) begin n_fails++; $display("FAIL nomask_grant: IrqReq=%b IrqId=%0d expected 1/0", IrqReq, IrqId); end
    drive_cycle(4'b0000, 1'b1);
  endtask
`endif

  task automatic test_reset_in_req();
    do_reset();
    drive_cycle(4'b0100, 1'b0);
    wait_req("rreq_wait");
    ARESET = 1'b1;
    drive_cycle(4'b1111, 1'b0);
    ARESET = 1'b0;
    n_checks++; if (IrqReq !== 1'b0 || Pending !== 4'b0000 || Overrun !== 4'b0000) begin n_fails++; $display("FAIL rreq_drop: IrqReq=%b Pending=%b Overrun=%b expected 0/0000/0000", IrqReq, Pending, Overrun); end
    drive_cycle(4'b0000, 1'b0);
    drive_cycle(4'b0000, 1'b0);
    n_checks++; if (IrqReq !== 1'b0) begin n_fails++; $display("FAIL rreq_idle: IrqReq=%b expected 0", IrqReq); end
  endtask

  task automatic test_random();
    logic [3:0] t;
    logic       a;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      t = 4'($urandom) & 4'($urandom);
      a = ($urandom_range(0, 2) == 0);
      drive_cycle(t, a);
      n_checks++; if (IrqReq !== m_req) begin n_fails++; $display("FAIL rnd_req c%0d: IrqReq=%b expected %b", c, IrqReq, m_req); end
      if (m_req) begin
        n_checks++; if (IrqId !== 2'(m_id)) begin n_fails++; $display("FAIL rnd_id c%0d: IrqId=%0d expected %0d", c, IrqId, m_id); end
      end
      n_checks++; if (Pending !== m_pend) begin n_fails++; $display("FAIL rnd_pend c%0d: Pending=%b expected %b", c, Pending, m_pend); end
      n_checks++; if (Overrun !== m_ovr) begin n_fails++; $display("FAIL rnd_ovr c%0d: Overrun=%b expected %b", c, Overrun, m_ovr); end
      n_checks++; if (SlaverWriteReady !== m_ready) begin n_fails++; $display("FAIL rnd_wrdy c%0d: SlaverWriteReady=%b expected %b", c, SlaverWriteReady, m_ready); end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_latency();
    test_simultaneous();
    test_overrun();
    test_ack_collision();
`ifdef TIMER_IRQ_MASK_EN
    test_mask();
`else
    test_no_mask();
`endif
    test_reset_in_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
